// File: rtl/code_stream_packer_if.sv
// Beat-in / word-out handshake bundle for code_stream_packer.
// The master modport is the producer of code beats and the consumer of packed words.
interface code_stream_packer_if #(
  parameter int OUT_W  = 32,
  parameter int CODE_W = 32
);
  localparam int LEN_W  = $clog2(CODE_W) + 1;
  localparam int BITS_W = $clog2(OUT_W) + 1;

  logic              in_valid;
  logic              in_ready;
  logic              a_en;
  logic [CODE_W-1:0] a_code;
  logic [LEN_W-1:0]  a_len;
  logic              b_en;
  logic [CODE_W-1:0] b_code;
  logic [LEN_W-1:0]  b_len;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_word;
  logic              out_last;
  logic [BITS_W-1:0] out_bits;

  modport master (
    output in_valid, a_en, a_code, a_len, b_en, b_code, b_len, flush, out_ready,
    input  in_ready, out_valid, out_word, out_last, out_bits
  );

  modport slave (
    input  in_valid, a_en, a_code, a_len, b_en, b_code, b_len, flush, out_ready,
    output in_ready, out_valid, out_word, out_last, out_bits
  );
endinterface

// File: rtl/code_stream_packer.sv
// Packs two variable-length codes per beat MSB-first into OUT_W-bit words,
// buffered by a small output FIFO; a flush beat closes the stream.
module code_stream_packer #(
  parameter int OUT_W      = 32,
  parameter int CODE_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  code_stream_packer_if.slave bus,
  output logic [31:0] total_bits,
  output logic        len_err
);
  localparam int LEN_W  = $clog2(CODE_W) + 1;
  localparam int BITS_W = $clog2(OUT_W) + 1;
  localparam int ACC_W  = OUT_W - 1 + 2 * CODE_W;
  localparam int CNT_W  = $clog2(ACC_W + 2 * OUT_W + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  ONE_W    = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0]  TWO_W    = CNT_W'(2 * OUT_W);
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(CODE_W);
  localparam logic [BITS_W-1:0] FULL_B   = BITS_W'(OUT_W);
  localparam logic [FCNT_W-1:0] DEPTH_C  = FCNT_W'(FIFO_DEPTH);

  logic [ACC_W-1:0]  acc_q, acc_d, comb_v, a_bits, b_bits;
  logic [CNT_W-1:0]  pend_q, n_v, rem_v;
  logic [LEN_W-1:0]  la, lb;
  logic              la_err, lb_err;
  logic [1:0]        nwords, npush;
  logic [OUT_W-1:0]  pw [3];
  logic              pl [3];
  logic [BITS_W-1:0] pb [3];

  logic [OUT_W-1:0]  mem_w [FIFO_DEPTH];
  logic              mem_l [FIFO_DEPTH];
  logic [BITS_W-1:0] mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [FCNT_W-1:0] fcount, free_c;
  logic              active, clr_q, fire, pop;

  assign free_c        = DEPTH_C - fcount;
  assign bus.in_ready  = active && (free_c >= FCNT_W'(3));
  assign bus.out_valid = (fcount != '0);
  assign bus.out_word  = bus.out_valid ? mem_w[rd_ptr] : '0;
  assign bus.out_last  = bus.out_valid ? mem_l[rd_ptr] : 1'b0;
  assign bus.out_bits  = bus.out_valid ? mem_b[rd_ptr] : '0;
  assign fire          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  always_comb begin
    la_err = bus.a_en && (bus.a_len > MAX_LEN);
    lb_err = bus.b_en && (bus.b_len > MAX_LEN);
    la = '0;
    lb = '0;
    if (bus.a_en) la = la_err ? MAX_LEN : bus.a_len;
    if (bus.b_en) lb = lb_err ? MAX_LEN : bus.b_len;
    a_bits = ACC_W'(bus.a_code) & ~({ACC_W{1'b1}} << la);
    b_bits = ACC_W'(bus.b_code) & ~({ACC_W{1'b1}} << lb);

    // Pending bits stay right-aligned, so appending is shift-then-OR.
    comb_v = (((acc_q << la) | a_bits) << lb) | b_bits;
    n_v    = pend_q + CNT_W'(la) + CNT_W'(lb);

    if (n_v >= TWO_W) begin
      nwords = 2'd2;
      rem_v  = n_v - TWO_W;
    end else if (n_v >= ONE_W) begin
      nwords = 2'd1;
      rem_v  = n_v - ONE_W;
    end else begin
      nwords = 2'd0;
      rem_v  = n_v;
    end
    acc_d = comb_v & ~({ACC_W{1'b1}} << rem_v);

    pw[0] = OUT_W'(comb_v >> (n_v - ONE_W));
    pw[1] = OUT_W'(comb_v >> (n_v - TWO_W));
    pw[2] = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      pl[i] = 1'b0;
      pb[i] = FULL_B;
    end
    npush = nwords;

    if (bus.flush) begin
      if (rem_v != '0) begin
        pw[nwords] = OUT_W'(comb_v << (ONE_W - rem_v));
        pl[nwords] = 1'b1;
        pb[nwords] = BITS_W'(rem_v);
        npush      = nwords + 2'd1;
      end else if (nwords != 2'd0) begin
        pl[nwords - 2'd1] = 1'b1;
      end else begin
        pw[0] = '0;
        pl[0] = 1'b1;
        pb[0] = '0;
        npush = 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active     <= 1'b0;
      acc_q      <= '0;
      pend_q     <= '0;
      total_bits <= '0;
      clr_q      <= 1'b0;
      len_err    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fcount     <= '0;
    end else begin
      active <= 1'b1;
      clr_q  <= fire && bus.flush;
      // A closed stream shows its final count for one cycle before clearing.
      total_bits <= (clr_q ? 32'd0 : total_bits) +
                    (fire ? (32'(la) + 32'(lb)) : 32'd0);
      if (fire) begin
        acc_q  <= bus.flush ? '0 : acc_d;
        pend_q <= bus.flush ? '0 : rem_v;
        wr_ptr <= wr_ptr + PTR_W'(npush);
        if (la_err || lb_err) len_err <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      fcount <= fcount + (fire ? FCNT_W'(npush) : '0) - FCNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (npush > 2'(i)) begin
          mem_w[wr_ptr + PTR_W'(i)] <= pw[i];
          mem_l[wr_ptr + PTR_W'(i)] <= pl[i];
          mem_b[wr_ptr + PTR_W'(i)] <= pb[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_code_stream_packer.sv
// Directed bench for code_stream_packer: hand-computed words, flags and counts.
module tb_code_stream_packer;
  logic clk;
  logic reset;
  logic [31:0] total_bits;
  logic len_err;
  int checks;
  int errors;

  logic [31:0] wq [$];
  logic        lq [$];
  logic [5:0]  bq [$];

  code_stream_packer_if #(.OUT_W(32), .CODE_W(32)) bus ();

  code_stream_packer #(.OUT_W(32), .CODE_W(32), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .total_bits (total_bits),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every word that will be popped at the coming rising edge.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      wq.push_back(bus.out_word);
      lq.push_back(bus.out_last);
      bq.push_back(bus.out_bits);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic ae, input logic [31:0] ac, input logic [5:0] al,
                      input logic be, input logic [31:0] bc, input logic [5:0] bl,
                      input logic fl);
    int k;
    bus.in_valid = 1'b1;
    bus.a_en = ae; bus.a_code = ac; bus.a_len = al;
    bus.b_en = be; bus.b_code = bc; bus.b_len = bl;
    bus.flush = fl;
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 50) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.a_en = 1'b0; bus.a_code = '0; bus.a_len = '0;
    bus.b_en = 1'b0; bus.b_code = '0; bus.b_len = '0;

    #2;
    chk("rst_in_ready",   64'(bus.in_ready), 64'd0);
    chk("rst_out_valid",  64'(bus.out_valid), 64'd0);
    chk("rst_out_word",   64'(bus.out_word), 64'd0);
    chk("rst_out_last",   64'(bus.out_last), 64'd0);
    chk("rst_out_bits",   64'(bus.out_bits), 64'd0);
    chk("rst_total_bits", 64'(total_bits), 64'd0);
    chk("rst_len_err",    64'(len_err), 64'd0);
    #21 reset = 1'b1;
    #1 chk("ready_before_edge", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_release", 64'(bus.in_ready), 64'd1);

    // 101 then 00011, closed by an empty flush beat.
    beat(1'b1, 32'h5, 6'd3, 1'b1, 32'h3, 6'd5, 1'b0);
    chk("t1_total_8", 64'(total_bits), 64'd8);
    chk("t1_no_word_yet", 64'(bus.out_valid), 64'd0);
    beat(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1);
    chk("t1_valid",  64'(bus.out_valid), 64'd1);
    chk("t1_word",   64'(bus.out_word), 64'hA3000000);
    chk("t1_last",   64'(bus.out_last), 64'd1);
    chk("t1_bits",   64'(bus.out_bits), 64'd8);
    chk("t1_total_before_clear", 64'(total_bits), 64'd8);
    @(posedge clk); #1;
    chk("t1_total_cleared", 64'(total_bits), 64'd0);
    chk("t1_popped", 64'(bus.out_valid), 64'd0);

    // Two full-width beats, flush on the second one.
    wq.delete(); lq.delete(); bq.delete();
    beat(1'b1, 32'hFFFFFFFF, 6'd32, 1'b1, 32'h0, 6'd32, 1'b0);
    beat(1'b1, 32'hFFFFFFFF, 6'd32, 1'b1, 32'h0, 6'd32, 1'b1);
    chk("t2_total_128", 64'(total_bits), 64'd128);
    settle(10);
    chk("t2_count", 64'(wq.size()), 64'd4);
    chk("t2_w0", 64'(wq[0]), 64'hFFFFFFFF);
    chk("t2_w1", 64'(wq[1]), 64'h00000000);
    chk("t2_w2", 64'(wq[2]), 64'hFFFFFFFF);
    chk("t2_w3", 64'(wq[3]), 64'h00000000);
    chk("t2_last_flags", 64'({lq[0], lq[1], lq[2], lq[3]}), 64'b0001);
    chk("t2_bits_all32", 64'({bq[0], bq[1], bq[2], bq[3]}), 64'({6'd32, 6'd32, 6'd32, 6'd32}));

    // Backpressure: one 64-bit beat fills two entries and drops in_ready.
    wq.delete(); lq.delete(); bq.delete();
    bus.out_ready = 1'b0;
    beat(1'b1, 32'h12345678, 6'd32, 1'b1, 32'h9ABCDEF0, 6'd32, 1'b0);
    chk("t3_valid", 64'(bus.out_valid), 64'd1);
    chk("t3_ready_low", 64'(bus.in_ready), 64'd0);
    chk("t3_total_64", 64'(total_bits), 64'd64);
    settle(3);
    chk("t3_word_held", 64'(bus.out_word), 64'h12345678);
    chk("t3_last_held", 64'(bus.out_last), 64'd0);
    bus.out_ready = 1'b1;
    settle(1);
    chk("t3_ready_back", 64'(bus.in_ready), 64'd1);
    chk("t3_second_word", 64'(bus.out_word), 64'h9ABCDEF0);
    beat(1'b0, 32'hFFFFFFFF, 6'd7, 1'b0, 32'hFFFFFFFF, 6'd9, 1'b1);
    settle(8);
    chk("t3_count", 64'(wq.size()), 64'd3);
    chk("t3_w0", 64'(wq[0]), 64'h12345678);
    chk("t3_w1", 64'(wq[1]), 64'h9ABCDEF0);
    chk("t3_empty_flush_word", 64'(wq[2]), 64'd0);
    chk("t3_empty_flush_last", 64'(lq[2]), 64'd1);
    chk("t3_empty_flush_bits", 64'(bq[2]), 64'd0);

    // Flush with a remainder in the same beat that completes a word.
    wq.delete(); lq.delete(); bq.delete();
    beat(1'b1, 32'hDEADBEEF, 6'd32, 1'b1, 32'hFFFFFFFF, 6'd4, 1'b1);
    chk("t4_total_36", 64'(total_bits), 64'd36);
    settle(6);
    chk("t4_count", 64'(wq.size()), 64'd2);
    chk("t4_w0", 64'({lq[0], bq[0], wq[0]}), 64'({1'b0, 6'd32, 32'hDEADBEEF}));
    chk("t4_w1", 64'({lq[1], bq[1], wq[1]}), 64'({1'b1, 6'd4, 32'hF0000000}));

    // Zero-length and disabled slots contribute nothing.
    wq.delete(); lq.delete(); bq.delete();
    beat(1'b1, 32'hFF, 6'd0, 1'b0, 32'hFF, 6'd8, 1'b0);
    chk("t5_total_0", 64'(total_bits), 64'd0);
    beat(1'b0, 32'hFFFF, 6'd8, 1'b1, 32'h5, 6'd3, 1'b1);
    chk("t5_total_3", 64'(total_bits), 64'd3);
    settle(6);
    chk("t5_count", 64'(wq.size()), 64'd1);
    chk("t5_w0", 64'({lq[0], bq[0], wq[0]}), 64'({1'b1, 6'd3, 32'hA0000000}));

    // Over-length code is clamped; async reset discards queued words.
    wq.delete(); lq.delete(); bq.delete();
    bus.out_ready = 1'b0;
    beat(1'b1, 32'hFFFFFFFF, 6'd33, 1'b1, 32'h12345678, 6'd32, 1'b0);
    chk("t6_len_err", 64'(len_err), 64'd1);
    chk("t6_total_64", 64'(total_bits), 64'd64);
    chk("t6_word0", 64'(bus.out_word), 64'hFFFFFFFF);
    chk("t6_ready_low", 64'(bus.in_ready), 64'd0);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_rst_len_err", 64'(len_err), 64'd0);
    chk("t6_rst_total", 64'(total_bits), 64'd0);
    chk("t6_rst_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready_after", 64'(bus.in_ready), 64'd1);
    chk("t6_fifo_empty", 64'(bus.out_valid), 64'd0);
    beat(1'b0, 32'h0, 6'd0, 1'b0, 32'h0, 6'd0, 1'b1);
    settle(6);
    chk("t6_count", 64'(wq.size()), 64'd1);
    chk("t6_post_flush", 64'({lq[0], bq[0], wq[0]}), 64'({1'b1, 6'd0, 32'h0}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
